// File: rtl/if_id_buf.sv
// IF/ID pipeline stage as a DEPTH-entry in-order buffer between fetch and decode.
// Presents the oldest entry pre-split into MIPS fields and counts decode bubbles.
module if_id_buf #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'hFC000000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [ADDR_W-1:0]            inst_addr_i,
  input  logic [31:0]                  inst_i,
  input  logic                         hd_i,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  output logic [ADDR_W-1:0]            inst_addr_o,
  output logic [31:0]                  inst_o,
  output logic [5:0]                   op_o,
  output logic [4:0]                   rs_o,
  output logic [4:0]                   rt_o,
  output logic [4:0]                   rd_o,
  output logic [15:0]                  imm16_o,
  output logic [25:0]                  jaddr_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic [CNT_W-1:0]             bubble_cnt_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [OccW-1:0] DepthCnt = OccW'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [31:0]       inst_mem [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             push, pop;
  logic [31:0]      head_inst;
  logic [ADDR_W-1:0] head_addr;

  // Ready looks only at registered occupancy, so a full buffer refuses even when popping.
  always_comb begin
    in_ready_o  = (cnt_q < DepthCnt);
    out_valid_o = (cnt_q != '0);
    push        = in_valid_i & in_ready_o & ~flush_i;
    pop         = out_valid_o & ~hd_i & ~flush_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + OccW'(1);
        2'b01:   cnt_d = cnt_q - OccW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Bubble counter survives flush; only reset clears it.
  always_comb begin
    bubble_d = bubble_q;
    if (!out_valid_o && (bubble_q != '1)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      bubble_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      bubble_q <= bubble_d;
    end
  end

  // Entry storage is deliberately unreset; validity comes from cnt and the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= inst_addr_i;
      inst_mem[wr_ptr_q] <= inst_i;
    end
  end

  always_comb begin
    head_inst = out_valid_o ? inst_mem[rd_ptr_q] : NOP_INST;
    head_addr = out_valid_o ? addr_mem[rd_ptr_q] : '0;
  end

  always_comb begin
    inst_o       = head_inst;
    inst_addr_o  = head_addr;
    op_o         = head_inst[31:26];
    rs_o         = head_inst[25:21];
    rt_o         = head_inst[20:16];
    rd_o         = head_inst[15:11];
    imm16_o      = head_inst[15:0];
    jaddr_o      = head_inst[25:0];
    occupancy_o  = cnt_q;
    bubble_cnt_o = bubble_q;
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: two instances (DEPTH=2/CNT_W=16 and DEPTH=3/CNT_W=4) share stimulus,
// each checked every cycle against a queue-based reference model.
module tb_if_id_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] inst = '0;
  logic        hd = 1'b0;
  logic        flush = 1'b0;

  logic        rdy_a, val_a, rdy_b, val_b;
  logic [31:0] addr_a, inst_a, addr_b, inst_b;
  logic [5:0]  op_a, op_b;
  logic [4:0]  rs_a, rt_a, rd_a, rs_b, rt_b, rd_b;
  logic [15:0] imm_a, imm_b;
  logic [25:0] jad_a, jad_b;
  logic [1:0]  occ_a, occ_b;
  logic [15:0] bub_a;
  logic [3:0]  bub_b;

  always #5 clk = ~clk;

  if_id_buf #(.ADDR_W(32), .DEPTH(2), .NOP_INST(32'hFC000000), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_a),
    .inst_addr_i(addr), .inst_i(inst), .hd_i(hd), .flush_i(flush),
    .out_valid_o(val_a), .inst_addr_o(addr_a), .inst_o(inst_a), .op_o(op_a),
    .rs_o(rs_a), .rt_o(rt_a), .rd_o(rd_a), .imm16_o(imm_a), .jaddr_o(jad_a),
    .occupancy_o(occ_a), .bubble_cnt_o(bub_a)
  );

  if_id_buf #(.ADDR_W(32), .DEPTH(3), .NOP_INST(32'hFC000000), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_b),
    .inst_addr_i(addr), .inst_i(inst), .hd_i(hd), .flush_i(flush),
    .out_valid_o(val_b), .inst_addr_o(addr_b), .inst_o(inst_b), .op_o(op_b),
    .rs_o(rs_b), .rt_o(rt_b), .rd_o(rd_b), .imm16_o(imm_b), .jaddr_o(jad_b),
    .occupancy_o(occ_b), .bubble_cnt_o(bub_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: each buffer is a plain FIFO queue of {addr, inst}.
  logic [63:0] mq_a[$];
  logic [63:0] mq_b[$];
  int          mbub_a = 0;
  int          mbub_b = 0;
  bit          acc_a, acc_b;
  bit          mon_en = 1'b0;

  always @(posedge clk) begin
    acc_a = 1'b0;
    acc_b = 1'b0;
    if (rst) begin
      mq_a.delete();
      mq_b.delete();
      mbub_a = 0;
      mbub_b = 0;
    end else begin
      if (mq_a.size() == 0 && mbub_a < 65535) mbub_a++;
      if (mq_b.size() == 0 && mbub_b < 15) mbub_b++;
      if (flush) begin
        mq_a.delete();
        mq_b.delete();
      end else begin
        bit full_a, full_b;
        full_a = (mq_a.size() >= 2);
        full_b = (mq_b.size() >= 3);
        if (mq_a.size() > 0 && !hd) void'(mq_a.pop_front());
        if (mq_b.size() > 0 && !hd) void'(mq_b.pop_front());
        if (in_valid && !full_a) begin
          mq_a.push_back({addr, inst});
          acc_a = 1'b1;
        end
        if (in_valid && !full_b) begin
          mq_b.push_back({addr, inst});
          acc_b = 1'b1;
        end
      end
    end
    mon_en = 1'b1;
  end

  // Monitor: compare both instances against the model head every cycle.
  int max_occ_b = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] ei, ea;
      ei = (mq_a.size() != 0) ? mq_a[0][31:0] : 32'hFC000000;
      ea = (mq_a.size() != 0) ? mq_a[0][63:32] : 32'h0;
      check("a_valid", 64'(val_a), 64'(mq_a.size() != 0));
      check("a_ready", 64'(rdy_a), 64'(mq_a.size() < 2));
      check("a_occ", 64'(occ_a), 64'(mq_a.size()));
      check("a_inst", 64'(inst_a), 64'(ei));
      check("a_addr", 64'(addr_a), 64'(ea));
      check("a_fields", {op_a, rs_a, rt_a, rd_a, jad_a},
            {ei[31:26], ei[25:21], ei[20:16], ei[15:11], ei[25:0]});
      check("a_imm", 64'(imm_a), 64'(ei[15:0]));
      check("a_bubble", 64'(bub_a), 64'(mbub_a));
      ei = (mq_b.size() != 0) ? mq_b[0][31:0] : 32'hFC000000;
      ea = (mq_b.size() != 0) ? mq_b[0][63:32] : 32'h0;
      check("b_valid", 64'(val_b), 64'(mq_b.size() != 0));
      check("b_ready", 64'(rdy_b), 64'(mq_b.size() < 3));
      check("b_occ", 64'(occ_b), 64'(mq_b.size()));
      check("b_inst", 64'(inst_b), 64'(ei));
      check("b_addr", 64'(addr_b), 64'(ea));
      check("b_fields", {op_b, rs_b, rt_b, rd_b, imm_b}, {ei[31:26], ei[25:21], ei[20:16],
            ei[15:11], ei[15:0]});
      check("b_jaddr", 64'(jad_b), 64'(ei[25:0]));
      check("b_bubble", 64'(bub_b), 64'(mbub_b));
      if (int'(occ_b) > max_occ_b) max_occ_b = int'(occ_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold an entry on the fetch side until instance A accepts it (bounded).
  task automatic offer_a(input logic [31:0] a, input logic [31:0] i);
    int n;
    in_valid = 1'b1;
    addr = a;
    inst = i;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_a && n < 40);
    if (!acc_a) check("offer_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset held two cycles.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(val_a), 64'(0));
    check("rst_inst", 64'(inst_a), 64'(32'hFC000000));
    check("rst_op", 64'(op_a), 64'(6'h3F));
    check("rst_ready", 64'(rdy_a), 64'(1));
    check("rst_bubble0", 64'(bub_a), 64'(0));
    step();
    @(negedge clk);
    check("rst_bubble1", 64'(bub_a), 64'(1));

    // Streaming with 1-cycle latency.
    step();
    in_valid = 1'b1; addr = 32'h00; inst = 32'h012A4020;
    step();
    addr = 32'h04; inst = 32'h8D090004;
    @(negedge clk);
    check("s1_inst", 64'(inst_a), 64'(32'h012A4020));
    step();
    addr = 32'h08; inst = 32'h08000010;
    @(negedge clk);
    check("s2_rs", 64'(rs_a), 64'(8));
    check("s2_rt", 64'(rt_a), 64'(9));
    check("s2_imm", 64'(imm_a), 64'(16'h0004));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("s3_jaddr", 64'(jad_a), 64'(26'h0000010));
    check("s3_addr", 64'(addr_a), 64'(32'h08));
    step();
    step();

    // Stall/fill on the DEPTH=2 instance.
    hd = 1'b1;
    offer_a(32'h100, 32'h20010001);
    offer_a(32'h104, 32'h20020002);
    in_valid = 1'b1; addr = 32'h108; inst = 32'h20030003;
    step();
    @(negedge clk);
    check("fill_occ", 64'(occ_a), 64'(2));
    check("fill_ready", 64'(rdy_a), 64'(0));
    check("fill_head", 64'(addr_a), 64'(32'h100));
    step();
    check("fill_refused", 64'(acc_a), 64'(0));
    hd = 1'b0;
    offer_a(32'h108, 32'h20030003);
    repeat (4) step();

    // Flush has priority over hd and over a pending push.
    hd = 1'b1;
    offer_a(32'h200, 32'h11111111);
    offer_a(32'h204, 32'h22222222);
    flush = 1'b1; in_valid = 1'b1; addr = 32'h208; inst = 32'h33333333;
    step();
    flush = 1'b0; in_valid = 1'b0; hd = 1'b0;
    @(negedge clk);
    check("flush_occ", 64'(occ_a), 64'(0));
    check("flush_valid", 64'(val_a), 64'(0));
    check("flush_inst", 64'(inst_a), 64'(32'hFC000000));
    check("flush_ready", 64'(rdy_a), 64'(1));

    // Wrap-around: 10 entries, hd pulsed every third cycle.
    begin
      int sent = 0;
      int cyc = 0;
      max_occ_b = 0;
      while (sent < 10 && cyc < 80) begin
        hd = (cyc % 3 == 2);
        in_valid = 1'b1;
        addr = 32'h300 + 32'(sent * 4);
        inst = 32'hA5000000 + 32'(sent);
        step();
        if (acc_b) sent++;
        cyc++;
      end
      in_valid = 1'b0;
      hd = 1'b0;
      check("wrap_sent", 64'(sent), 64'(10));
      repeat (5) step();
      check("wrap_maxocc", 64'(max_occ_b <= 3), 64'(1));
    end

    // Bubble saturation on the CNT_W=4 instance.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    check("sat_10", 64'(bub_b), 64'(10));
    repeat (10) step();
    check("sat_20", 64'(bub_b), 64'(15));
    repeat (3) step();
    check("sat_hold", 64'(bub_b), 64'(15));

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      hd       = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 49) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      addr     = $urandom;
      inst     = $urandom;
      step();
    end
    in_valid = 1'b0; hd = 1'b0; flush = 1'b0; rst = 1'b0;
    step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
